fp_mul_round_normalize: RTL and testbench
=========================================

Name: fp_mul_round_normalize

Overview:
- Pipelined back-end of the single-precision FP multiply path. It sits directly downstream of the 24x24 mantissa multiplier and consumes its 48-bit product, sign and pre-biased exponent sum.
- It normalises the product, rounds to nearest-even, handles overflow/underflow/specials, and packs an IEEE-754 binary32 result.
- It has two register stages with valid/ready handshakes on both sides.

Parameters:
- EXP_W, 10, width of signed two's-complement exponent sum input.
- BIAS, 127, exponent bias (used only for range checks and documentation; input is already biased).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream holds a valid operand set
- in_ready  output  1  block accepts this cycle when in_valid & in_ready
- sign_in  input  1  sign_a XOR sign_b
- exp_sum  input  EXP_W  exp_a + exp_b - BIAS, signed
- product  input  48  man_a*man_b, hidden bits included
- spec_in  input  2  00 normal, 01 zero, 10 inf, 11 NaN (from upstream classifier)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- result  output  32  packed binary32
- flags  output  3  {overflow, underflow, inexact}

Behaviour:
- Reset (async, active-high): s1_valid=0, s2_valid=0; out_valid=0, result=0, flags=0. in_ready=1 after reset release. Reset mid-operation discards all in-flight data; no partial output.
- Handshake:
  - s2_load = s1_valid & (~s2_valid | out_ready).
  - in_ready = ~s1_valid | s2_load.
  - Stage 1 loads on in_valid & in_ready. Stage 1 clears when s2_load & ~(in_valid & in_ready).
  - out_valid = s2_valid. result/flags hold stable while out_valid & ~out_ready.
  - Full throughput: one result per cycle when out_ready=1. Latency is 2 cycles from accept to out_valid.
- Stage 1 (normalise):
  - If product[47]: mant=product[46:24], g=product[23], s=|product[22:0], e=exp_sum+1.
  - Else: mant=product[45:23], g=product[22], s=|product[21:0], e=exp_sum.
  - Register mant(23), g, s, e(EXP_W), sign, spec.
- Stage 2 (round/pack):
  - rup = g & (s | mant[0]).
  - m24 = {1'b0,mant} + rup. If m24[23]: frac=0 and e=e+1. Else frac=m24[22:0].
  - inexact = g|s.
  - If e >= 255: result={sign,8'hFF,23'h0}, overflow=1, inexact=1.
  - Else if e <= 0: flush to signed zero {sign,31'h0}, underflow=1, inexact=1. No subnormal output.
  - Else: result={sign,e[7:0],frac}.
- Specials override all arithmetic:
  - zero -> {sign,31'h0}
  - inf -> {sign,8'hFF,23'h0}
  - NaN -> 32'h7FC00000
  - Flags are 0 for all specials.
- Exponent arithmetic is signed EXP_W; no wrap is permitted in the range exp_sum in [-254, 381].
- Simultaneous accept and emit in the same cycle is legal and loses no data.

Test Plan:
- Reset, then product=48'h400000000000, exp_sum=127, sign=0, out_ready=1 -> 2 cycles later out_valid=1, result=32'h3F800000, flags=000.
- product=48'h900000000000 (1.5*1.5), exp_sum=127 -> result=32'h40100000, flags=000.
- Tie cases with exp_sum=127:
  - product=48'h400000400000 -> result=32'h3F800000, inexact=1 (tie to even, no increment).
  - product=48'h400000C00000 -> result=32'h3F800002, inexact=1.
- Rounding carry: product=48'h7FFFFFC00000, exp_sum=127 -> mantissa carry-out, result=32'h40000000, inexact=1.
- Range limits, both with product=48'h800000000000:
  - exp_sum=254 -> result=32'h7F800000, flags=101.
  - exp_sum=-1, sign=1 -> result=32'h80000000, flags=011.
- Backpressure and reset:
  - Send 3 back-to-back inputs with out_ready=0 -> in_ready drops after 2 accepts; result stays stable.
  - Raise out_ready -> all 3 results emerge in order on consecutive cycles.
  - Assert rst mid-stream -> out_valid=0 immediately; nothing in flight is emitted after release.

Source files
------------

// File: rtl/fp_mul_round_normalize_if.sv
// Handshake and data bundle for the FP multiply back-end.
//   master : upstream/downstream side (drives operands and out_ready)
//   slave  : the back-end itself (drives in_ready, out_valid, result, flags)
// Signals:
//   in_valid/in_ready   operand handshake
//   sign_in             sign_a ^ sign_b
//   exp_sum             exp_a + exp_b - BIAS, signed two's complement
//   product             48-bit mantissa product, hidden bits included
//   spec_in             00 normal, 01 zero, 10 inf, 11 NaN
//   out_valid/out_ready result handshake
//   result              packed binary32
//   flags               {overflow, underflow, inexact}
interface fp_mul_round_normalize_if #(
  parameter int EXP_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic             sign_in;
  logic [EXP_W-1:0] exp_sum;
  logic [47:0]      product;
  logic [1:0]       spec_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      result;
  logic [2:0]       flags;

  modport master (
    output in_valid, sign_in, exp_sum, product, spec_in, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, sign_in, exp_sum, product, spec_in, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_mul_round_normalize.sv
// Back-end of the binary32 multiply path: normalises the 48-bit mantissa
// product, rounds to nearest-even, resolves overflow/underflow/specials and
// packs the result. Two register stages, valid/ready on both sides, one
// result per cycle when downstream is ready.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  fp_mul_round_normalize_if.slave (operands in, result/flags out)
module fp_mul_round_normalize #(
  parameter int EXP_W = 10,
  parameter int BIAS  = 127
) (
  input  logic                      clk,
  input  logic                      rst,
  fp_mul_round_normalize_if.slave   bus
);

  localparam logic [EXP_W-1:0] E_MAX = EXP_W'(2*BIAS + 1);

  localparam logic [1:0] SPEC_NORM = 2'b00;
  localparam logic [1:0] SPEC_ZERO = 2'b01;
  localparam logic [1:0] SPEC_INF  = 2'b10;

  typedef struct packed {
    logic [22:0]      mant;
    logic             g;
    logic             s;
    logic [EXP_W-1:0] e;
    logic             sign;
    logic [1:0]       spec;
  } s1_t;

  s1_t         s1_d, s1_q;
  logic        s1_valid, s2_valid;
  logic        accept, s2_load;
  logic [31:0] res_d, res_q;
  logic [2:0]  flg_d, flg_q;

  // ---------------- handshake ----------------
  assign s2_load       = s1_valid & (~s2_valid | bus.out_ready);
  assign bus.in_ready  = ~s1_valid | s2_load;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.result    = res_q;
  assign bus.flags     = flg_q;

  // ---------------- stage 1: normalise ----------------
  // Product of two [1,2) mantissas lies in [1,4): bit 47 set means the
  // leading one is one position higher, so shift right and bump exponent.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = bus.sign_in;
    s1_d.spec = bus.spec_in;
    if (bus.product[47]) begin
      s1_d.mant = bus.product[46:24];
      s1_d.g    = bus.product[23];
      s1_d.s    = |bus.product[22:0];
      s1_d.e    = bus.exp_sum + EXP_W'(1);
    end else begin
      s1_d.mant = bus.product[45:23];
      s1_d.g    = bus.product[22];
      s1_d.s    = |bus.product[21:0];
      s1_d.e    = bus.exp_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_q     <= s1_d;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // ---------------- stage 2: round / pack ----------------
  logic             rup, inexact;
  logic [23:0]      m24;
  logic [EXP_W-1:0] e_rnd;
  logic [22:0]      frac;

  always_comb begin
    rup     = s1_q.g & (s1_q.s | s1_q.mant[0]);
    m24     = {1'b0, s1_q.mant} + {23'b0, rup};
    // Mantissa carry-out: 1.111..1 rounded up becomes 10.000..0.
    e_rnd   = s1_q.e + {{(EXP_W-1){1'b0}}, m24[23]};
    frac    = m24[23] ? 23'h0 : m24[22:0];
    inexact = s1_q.g | s1_q.s;
    res_d   = '0;
    flg_d   = '0;
    case (s1_q.spec)
      SPEC_NORM: begin
        // Exponent is signed; test the sign bit first so that negative
        // values never satisfy the unsigned overflow compare.
        if (!e_rnd[EXP_W-1] && (e_rnd >= E_MAX)) begin
          res_d = {s1_q.sign, 8'hFF, 23'h0};
          flg_d = 3'b101;
        end else if (e_rnd[EXP_W-1] || (e_rnd == '0)) begin
          res_d = {s1_q.sign, 31'h0};
          flg_d = 3'b011;
        end else begin
          res_d = {s1_q.sign, e_rnd[7:0], frac};
          flg_d = {2'b00, inexact};
        end
      end
      SPEC_ZERO: res_d = {s1_q.sign, 31'h0};
      SPEC_INF:  res_d = {s1_q.sign, 8'hFF, 23'h0};
      default:   res_d = 32'h7FC0_0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      res_q    <= '0;
      flg_q    <= '0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        res_q    <= res_d;
        flg_q    <= flg_d;
      end else if (bus.out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_round_normalize.sv
module tb_fp_mul_round_normalize;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_mul_round_normalize_if #(.EXP_W(10)) bus ();

  fp_mul_round_normalize #(.EXP_W(10), .BIAS(127)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [34:0] sb[$];       // expected {result, flags}
  int          pop_cyc[$];  // cycle of each scoreboard pop

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a transfer is out_valid & out_ready, sampled mid-cycle
  // (inputs only change just after the rising edge).
  logic        stall_prev = 1'b0;
  logic [34:0] held;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {bus.result, bus.flags}, 35'h0);
          if ({bus.result, bus.flags} == 35'h0) begin
            bad++;
            $display("FAIL unexpected_output: got zero result with empty scoreboard");
          end
        end else begin
          chk("result_flags", {bus.result, bus.flags}, sb.pop_front());
          pop_cyc.push_back(cyc);
        end
      end
      if (bus.out_valid && !bus.out_ready) begin
        if (stall_prev) chk("hold_stable", {bus.result, bus.flags}, held);
        held       = {bus.result, bus.flags};
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic set_in(input logic s, input int e, input logic [47:0] p, input logic [1:0] sp);
    bus.in_valid = 1'b1;
    bus.sign_in  = s;
    bus.exp_sum  = 10'(e);
    bus.product  = p;
    bus.spec_in  = sp;
  endtask

  task automatic send(input logic s, input int e, input logic [47:0] p, input logic [1:0] sp,
                      input logic [34:0] exp);
    bit acc = 1'b0;
    int n = 0;
    set_in(s, e, p, sp);
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) sb.push_back(exp);
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", {63'h0, acc}, 64'h1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(sb.size()), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.sign_in   = 1'b0;
    bus.exp_sum   = '0;
    bus.product   = '0;
    bus.spec_in   = '0;
    bus.out_ready = 1'b1;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("rst_result", {32'h0, bus.result}, 64'h0);
    chk("rst_flags", {61'h0, bus.flags}, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", {63'h0, bus.in_ready}, 64'h1);

    // ---- 1.0 * 1.0, latency ----
    send(1'b0, 127, 48'h4000_0000_0000, 2'b00, {32'h3F80_0000, 3'b000});
    chk("lat_not_yet", {63'h0, bus.out_valid}, 64'h0);
    @(posedge clk); #1;
    chk("lat_valid", {63'h0, bus.out_valid}, 64'h1);
    chk("lat_result", {32'h0, bus.result}, 64'h3F80_0000);
    drain();

    // ---- back-to-back directed vectors, out_ready=1 ----
    send(1'b0,  127, 48'h9000_0000_0000, 2'b00, {32'h4010_0000, 3'b000}); // 1.5*1.5
    send(1'b0,  127, 48'h4000_0040_0000, 2'b00, {32'h3F80_0000, 3'b001}); // tie, even
    send(1'b0,  127, 48'h4000_00C0_0000, 2'b00, {32'h3F80_0002, 3'b001}); // tie, odd
    send(1'b0,  127, 48'h7FFF_FFC0_0000, 2'b00, {32'h4000_0000, 3'b001}); // carry-out
    send(1'b0,  254, 48'h8000_0000_0000, 2'b00, {32'h7F80_0000, 3'b101}); // overflow
    send(1'b1,   -1, 48'h8000_0000_0000, 2'b00, {32'h8000_0000, 3'b011}); // underflow
    send(1'b1,  127, 48'h4000_0000_0000, 2'b11, {32'h7FC0_0000, 3'b000}); // NaN
    send(1'b1,  300, 48'h8000_0000_0000, 2'b10, {32'hFF80_0000, 3'b000}); // inf
    send(1'b0, -200, 48'h7FFF_FFC0_0000, 2'b01, {32'h0000_0000, 3'b000}); // zero
    drain();

    // ---- backpressure ----
    bus.out_ready = 1'b0;
    send(1'b1, 127, 48'h4000_0000_0000, 2'b00, {32'hBF80_0000, 3'b000}); // A
    send(1'b0, 128, 48'h9000_0000_0000, 2'b00, {32'h4090_0000, 3'b000}); // B
    set_in(1'b0, 126, 48'h4000_00C0_0000, 2'b00);                          // C
    @(negedge clk);
    chk("bp_in_ready_low", {63'h0, bus.in_ready}, 64'h0);
    repeat (3) @(negedge clk);
    chk("bp_out_valid", {63'h0, bus.out_valid}, 64'h1);
    chk("bp_result_head", {32'h0, bus.result}, 64'hBF80_0000);
    @(posedge clk); #1;
    pop_cyc.delete();
    bus.out_ready = 1'b1;
    send(1'b0, 126, 48'h4000_00C0_0000, 2'b00, {32'h3F00_0002, 3'b001});
    drain();
    chk("bp_pop_count", 64'(pop_cyc.size()), 64'h3);
    if (pop_cyc.size() == 3) begin
      chk("bp_consec_1", 64'(pop_cyc[1] - pop_cyc[0]), 64'h1);
      chk("bp_consec_2", 64'(pop_cyc[2] - pop_cyc[1]), 64'h1);
    end

    // ---- reset mid-stream ----
    bus.out_ready = 1'b0;
    send(1'b0, 127, 48'h4000_0000_0000, 2'b00, {32'h3F80_0000, 3'b000});
    send(1'b0, 127, 48'h9000_0000_0000, 2'b00, {32'h4010_0000, 3'b000});
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("midrst_result", {32'h0, bus.result}, 64'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("postrst_out_valid", {63'h0, bus.out_valid}, 64'h0);

    // ---- recovery after reset ----
    send(1'b1, 130, 48'h9000_0000_0000, 2'b00, {32'hC190_0000, 3'b000});
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
